// File: rtl/seq_detect_scheduler_if.sv
// Bundle of the per-channel bit handshake, the match event and the counter read port of
// seq_detect_scheduler.
//   master : serial front-end / status side (drives bit_valid, bit_in, cnt_sel)
//   slave  : the scheduler (drives bit_ready, match_valid, match_ch, cnt_data)
//   bit_valid/bit_in/bit_ready : NCH-wide per-channel bit offer, bit and grant
//   match_valid/match_ch       : registered match pulse and its channel tag
//   cnt_sel/cnt_data           : combinational read of one per-channel match counter
interface seq_detect_scheduler_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]   bit_valid;
  logic [NCH-1:0]   bit_in;
  logic [NCH-1:0]   bit_ready;
  logic             match_valid;
  logic [CHW-1:0]   match_ch;
  logic [CHW-1:0]   cnt_sel;
  logic [CNT_W-1:0] cnt_data;

  modport master (
    output bit_valid, bit_in, cnt_sel,
    input  bit_ready, match_valid, match_ch, cnt_data
  );

  modport slave (
    input  bit_valid, bit_in, cnt_sel,
    output bit_ready, match_valid, match_ch, cnt_data
  );
endinterface

// File: rtl/seq_detect_scheduler.sv
// One overlapping serial pattern detector time-shared among NCH bit channels. A round-robin
// arbiter accepts at most one bit per cycle; each channel keeps its own history and fill
// count, so every channel behaves as an independent detector. Matches produce a tagged,
// one-cycle-latency event and bump a saturating per-channel counter.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   i_en    : arbitration enable (0 = accept nothing)
//   i_clear : synchronous clear of all context, counters, pointer and match output
//   io_bus  : slave side of seq_detect_scheduler_if (bit handshake, match event, counter read)
module seq_detect_scheduler #(
  parameter int unsigned        NCH     = 4,
  parameter int unsigned        PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] PATTERN = 3'b101,
  parameter int unsigned        CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_en,
  input  logic                   i_clear,
  seq_detect_scheduler_if.slave  io_bus
);

  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned HW  = PAT_LEN - 1;
  localparam int unsigned FW  = $clog2(PAT_LEN);
  localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_LEN - 1);
  localparam logic [CHW-1:0] LAST_RST = CHW'(NCH - 1);

  logic [NCH-1:0][HW-1:0]    r_hist;
  logic [NCH-1:0][FW-1:0]    r_fill;
  logic [NCH-1:0][CNT_W-1:0] r_cnt;
  logic [CHW-1:0]            r_last;
  logic                      r_match_valid;
  logic [CHW-1:0]            r_match_ch;

  logic [NCH-1:0]  w_grant;
  logic [CHW-1:0]  w_gnt_idx;
  logic            w_accept;
  logic            w_bit;
  logic [HW-1:0]   w_hist;
  logic [FW-1:0]   w_fill;
  logic [HW:0]     w_win;
  logic            w_match;

  // (base + k) mod NCH, evaluated in 32 bits so non-power-of-two NCH wraps correctly.
  function automatic logic [CHW-1:0] wrap_idx(input logic [CHW-1:0] base, input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    return CHW'(s % NCH);
  endfunction

  // Round-robin: first valid channel starting just after the last granted one.
  always_comb begin
    logic [CHW-1:0] idx;
    w_grant   = '0;
    w_gnt_idx = '0;
    w_accept  = 1'b0;
    idx       = '0;
    if (i_en && !i_clear) begin
      for (int unsigned k = 1; k <= NCH; k++) begin
        idx = wrap_idx(r_last, k);
        if (!w_accept && io_bus.bit_valid[idx]) begin
          w_accept       = 1'b1;
          w_gnt_idx      = idx;
          w_grant[idx]   = 1'b1;
        end
      end
    end
  end

  // Grant is only ever given to a valid channel, so a grant is an acceptance.
  assign io_bus.bit_ready = w_grant;

  assign w_bit   = io_bus.bit_in[w_gnt_idx];
  assign w_hist  = r_hist[w_gnt_idx];
  assign w_fill  = r_fill[w_gnt_idx];
  assign w_win   = {w_hist, w_bit};
  // Fill guard stops a fresh channel from matching on reset-zero history.
  assign w_match = w_accept && (w_fill == FILL_MAX) && (w_win == PATTERN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist        <= '0;
      r_fill        <= '0;
      r_cnt         <= '0;
      r_last        <= LAST_RST;
      r_match_valid <= 1'b0;
      r_match_ch    <= '0;
    end else if (i_clear) begin
      r_hist        <= '0;
      r_fill        <= '0;
      r_cnt         <= '0;
      r_last        <= LAST_RST;
      r_match_valid <= 1'b0;
      r_match_ch    <= '0;
    end else begin
      r_match_valid <= w_match;
      if (w_match) begin
        r_match_ch <= w_gnt_idx;
      end
      if (w_accept) begin
        r_last            <= w_gnt_idx;
        // History keeps shifting through a match, giving overlapping detection.
        r_hist[w_gnt_idx] <= w_win[HW-1:0];
        if (w_fill != FILL_MAX) begin
          r_fill[w_gnt_idx] <= w_fill + 1'b1;
        end
        if (w_match && (r_cnt[w_gnt_idx] != '1)) begin
          r_cnt[w_gnt_idx] <= r_cnt[w_gnt_idx] + 1'b1;
        end
      end
    end
  end

  assign io_bus.match_valid = r_match_valid;
  assign io_bus.match_ch    = r_match_ch;

  // Out-of-range selects (NCH not a power of two) read as zero.
  assign io_bus.cnt_data = ({1'b0, io_bus.cnt_sel} < (CHW + 1)'(NCH)) ?
                           r_cnt[io_bus.cnt_sel] : '0;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed bench for seq_detect_scheduler: a PATTERN=101 instance for most scenarios and a
// PATTERN=000 instance for the fill-guard / overlap case.
module tb_seq_detect_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic clr;
  logic clr0;

  int n_checks = 0;
  int n_errs   = 0;
  int n_pulses;

  always #5 clk = ~clk;

  seq_detect_scheduler_if #(.NCH(4), .CNT_W(8)) bus  ();
  seq_detect_scheduler_if #(.NCH(4), .CNT_W(8)) bus0 ();

  seq_detect_scheduler #(
    .NCH(4), .PAT_LEN(3), .PATTERN(3'b101), .CNT_W(8)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (en),
    .i_clear (clr),
    .io_bus  (bus)
  );

  seq_detect_scheduler #(
    .NCH(4), .PAT_LEN(3), .PATTERN(3'b000), .CNT_W(8)
  ) u_dut0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (en),
    .i_clear (clr0),
    .io_bus  (bus0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    bus.bit_valid  = '0;
    bus.bit_in     = '0;
    bus.cnt_sel    = '0;
    bus0.bit_valid = '0;
    bus0.bit_in    = '0;
    bus0.cnt_sel   = '0;
    en    = 1'b1;
    clr   = 1'b0;
    clr0  = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offer one bit on a single channel of the 101 instance; expects an immediate grant.
  task automatic send_bit(input int ch, input logic b, input logic exp_mv, input string tag);
    bus.bit_valid = 4'(1 << ch);
    bus.bit_in    = 4'(b) << ch;
    #1;
    check({tag, "_rdy"}, 32'(bus.bit_ready), 32'(1 << ch));
    @(posedge clk);
    #1;
    check({tag, "_mv"}, 32'(bus.match_valid), 32'(exp_mv));
    if (exp_mv) check({tag, "_mch"}, 32'(bus.match_ch), 32'(ch));
  endtask

  logic t1_b  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic t1_mv [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  logic [3:0] t3_vld [5] = '{4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0010};
  logic       t3_b1  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic       t3_b2  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [3:0] t3_gnt [5] = '{4'b0010, 4'b0100, 4'b0010, 4'b0100, 4'b0010};
  logic       t3_mv  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  logic t4_mv [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    // Reset state
    do_reset();
    check("rst_mv", 32'(bus.match_valid), 32'd0);
    check("rst_mch", 32'(bus.match_ch), 32'd0);
    check("rst_cnt", 32'(bus.cnt_data), 32'd0);
    check("rst_rdy", 32'(bus.bit_ready), 32'd0);

    // en=0 blocks grants
    en = 1'b0;
    bus.bit_valid = 4'b0001;
    #1;
    check("en0_rdy", 32'(bus.bit_ready), 32'd0);
    @(posedge clk);
    #1;
    en = 1'b1;

    // Ch0 alone: 1,0,1,0,1 -> matches after 3rd and 5th bit
    for (int k = 0; k < 5; k++) send_bit(0, t1_b[k], t1_mv[k], $sformatf("t1_%0d", k));
    bus.bit_valid = '0;
    bus.cnt_sel   = 2'd0;
    #1;
    check("t1_cnt", 32'(bus.cnt_data), 32'd2);
    @(posedge clk);
    #1;
    check("t1_pulse_end", 32'(bus.match_valid), 32'd0);

    // All channels valid: grants 0,1,2,3,0,1
    do_reset();
    bus.bit_valid = 4'hF;
    bus.bit_in    = 4'h0;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("t2_gnt%0d", k), 32'(bus.bit_ready), 32'(1 << (k % 4)));
      @(posedge clk);
    end
    #1;
    bus.bit_valid = '0;

    // Interleave ch1 (1,0,1) with ch2 (1,1): only ch1 matches
    do_reset();
    for (int k = 0; k < 5; k++) begin
      bus.bit_valid = t3_vld[k];
      bus.bit_in    = {1'b0, t3_b2[k], t3_b1[k], 1'b0};
      #1;
      check($sformatf("t3_gnt%0d", k), 32'(bus.bit_ready), 32'(t3_gnt[k]));
      @(posedge clk);
      #1;
      check($sformatf("t3_mv%0d", k), 32'(bus.match_valid), 32'(t3_mv[k]));
      if (t3_mv[k]) check("t3_mch", 32'(bus.match_ch), 32'd1);
    end
    bus.bit_valid = '0;
    bus.cnt_sel   = 2'd1;
    #1;
    check("t3_cnt1", 32'(bus.cnt_data), 32'd1);
    bus.cnt_sel = 2'd2;
    #1;
    check("t3_cnt2", 32'(bus.cnt_data), 32'd0);

    // PATTERN=000 instance: 0,0 no match, 3rd and 4th zero both match
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bus0.bit_valid = 4'b0001;
      bus0.bit_in    = 4'b0000;
      @(posedge clk);
      #1;
      check($sformatf("t4_mv%0d", k), 32'(bus0.match_valid), 32'(t4_mv[k]));
      if (t4_mv[k]) check("t4_mch", 32'(bus0.match_ch), 32'd0);
    end
    bus0.bit_valid = '0;
    #1;
    check("t4_cnt", 32'(bus0.cnt_data), 32'd2);

    // 300 matches on ch3 saturate the counter at 255
    do_reset();
    n_pulses = 0;
    bus.cnt_sel = 2'd3;
    for (int n = 0; n < 601; n++) begin
      bus.bit_valid = 4'b1000;
      bus.bit_in    = (n % 2 == 0) ? 4'b1000 : 4'b0000;
      @(posedge clk);
      #1;
      if (bus.match_valid) n_pulses++;
    end
    check("t5_pulses", 32'(n_pulses), 32'd300);
    check("t5_sat", 32'(bus.cnt_data), 32'd255);
    // clear cycle: no grant, then everything back to reset
    clr = 1'b1;
    bus.bit_valid = 4'b1000;
    bus.bit_in    = 4'b0000;
    #1;
    check("t5_clr_rdy", 32'(bus.bit_ready), 32'd0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    bus.bit_valid = '0;
    check("t5_clr_cnt", 32'(bus.cnt_data), 32'd0);
    check("t5_clr_mv", 32'(bus.match_valid), 32'd0);
    send_bit(3, 1'b0, 1'b0, "t5_a");
    send_bit(3, 1'b1, 1'b0, "t5_b");
    bus.bit_valid = '0;

    // Asynchronous reset mid-stream
    do_reset();
    send_bit(0, 1'b1, 1'b0, "t6_a");
    send_bit(0, 1'b0, 1'b0, "t6_b");
    send_bit(2, 1'b1, 1'b0, "t6_c");
    send_bit(2, 1'b0, 1'b0, "t6_d");
    send_bit(2, 1'b1, 1'b1, "t6_e");
    bus.bit_valid = '0;
    bus.cnt_sel   = 2'd2;
    #1;
    check("t6_cnt_pre", 32'(bus.cnt_data), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_mv", 32'(bus.match_valid), 32'd0);
    check("t6_rst_mch", 32'(bus.match_ch), 32'd0);
    check("t6_rst_cnt", 32'(bus.cnt_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_bit(0, 1'b1, 1'b0, "t6_f");
    send_bit(0, 1'b0, 1'b0, "t6_g");
    send_bit(0, 1'b1, 1'b1, "t6_h");
    bus.bit_valid = '0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
